// File: rtl/tff_pkg.sv
// Shared helpers for the T flip-flop counter slice.
// Width helper, direction constants and binary-to-Gray conversion.
package tff_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((n - 1) >> i) != 0) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Sized for the widest legal counter (MOD up to 65536).
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop cell: toggles when t is high.
// Synchronous active-high reset clears the cell.
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= t ^ q;
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_sync_counter.sv
// Modulo-MOD up/down counter built from a row of T flip-flop cells.
// Define TFF_SYNC_COUNTER_GRAY_EN to add a registered Gray-coded output.
module tff_sync_counter
  import tff_pkg::*;
#(
  parameter int MOD = 10,
  parameter int W   = clog2_safe(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic         tc,
  output logic [W-1:0] t_dbg
`ifdef TFF_SYNC_COUNTER_GRAY_EN
  ,
  output logic [W-1:0] gray
`endif
);

  localparam logic [W-1:0] MAX_Q = W'(MOD - 1);

  logic [W-1:0] q_eff;
  logic [W-1:0] din_c;
  logic [W-1:0] nxt;
  logic         cnt_up;
  logic         cnt_dn;

  // Out-of-range state behaves as MOD-1 so one enabled edge recovers it.
  assign q_eff  = (q > MAX_Q) ? MAX_Q : q;
  assign din_c  = (din > MAX_Q) ? MAX_Q : din;
  assign cnt_up = !load && en && (up == DIR_UP);
  assign cnt_dn = !load && en && (up == DIR_DN);

  always_comb begin
    nxt = q;
    unique case (1'b1)
      load:   nxt = din_c;
      cnt_up: nxt = (q_eff == MAX_Q) ? '0 : q_eff + 1'b1;
      cnt_dn: nxt = (q_eff == '0) ? MAX_Q : q_eff - 1'b1;
      default: nxt = q;
    endcase
  end

  assign t_dbg = rst ? '0 : (nxt ^ q);

  assign tc = en && !load && !rst &&
              ((up && (q == MAX_Q)) || (!up && (q == '0)));

  for (genvar i = 0; i < W; i++) begin : g_cell
    tff_cell u_cell (
      .t   (t_dbg[i]),
      .clk (clk),
      .rst (rst),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

`ifdef TFF_SYNC_COUNTER_GRAY_EN
  always_ff @(posedge clk) begin
    if (rst) gray <= '0;
    else     gray <= W'(bin2gray(16'(nxt)));
  end
`endif

endmodule
